// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stall_ctrl
// Description : Pipeline hazard and multi-cycle sequencing controller for the
//               five-stage core. It detects load-use hazards that the EX/MEM/WB
//               forwarding paths cannot cover and inserts a single bubble for
//               each one. It also sequences the external iterative divider:
//               PC..EX are held until the divider finishes or the watchdog
//               fires, the result is latched, and the pipe is released once.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                 core clock
//   rst                 asynchronous active-high reset
//   flush_i             exception/eret flush, cancels any divide in progress
//   id_rs_ren_i/id_rs_i ID-stage rs read enable / address
//   id_rt_ren_i/id_rt_i ID-stage rt read enable / address
//   ex_is_load_i        instruction in EX is a load
//   ex_wreg_i           EX instruction writes the register file
//   ex_waddr_i          EX destination register
//   ex_div_req_i        valid divide instruction in EX
//   div_ready_i         divider result valid (single-cycle pulse)
//   div_result_i        divider result {hi, lo}
//   stall_o             per-stage hold: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   div_start_o         one-cycle start pulse to the divider
//   div_cancel_o        one-cycle abort to the divider
//   div_result_q_o      latched divider result
//   div_result_valid_o  latched result is usable by EX this cycle
//   div_timeout_o       sticky watchdog flag
//   load_stall_cnt_o    saturating count of load-use stall cycles
//   div_stall_cnt_o     saturating count of divide stall cycles
// ============================================================================
module stall_ctrl #(
    parameter int DIV_MAX_CYCLES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        id_rs_ren_i,
    input  logic [4:0]  id_rs_i,
    input  logic        id_rt_ren_i,
    input  logic [4:0]  id_rt_i,
    input  logic        ex_is_load_i,
    input  logic        ex_wreg_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic        ex_div_req_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic [5:0]  stall_o,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic [63:0] div_result_q_o,
    output logic        div_result_valid_o,
    output logic        div_timeout_o,
    output logic [31:0] load_stall_cnt_o,
    output logic [31:0] div_stall_cnt_o
);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LOAD = 6'b000111;  // hold PC/IF/ID, bubble into EX
    localparam logic [5:0] STALL_DIV  = 6'b001111;  // hold PC..EX while dividing
    localparam logic [5:0] CYC_LAST   = 6'(DIV_MAX_CYCLES - 1);
    localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_RUN  = 2'd1,
        ST_DIV_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cyc_q, cyc_d;
    logic [63:0] div_result_q, div_result_d;
    logic        div_timeout_q, div_timeout_d;
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [31:0] div_cnt_q, div_cnt_d;

    // Ungated combinational decisions; the outputs are these forced to zero
    // while rst is high so nothing leaks out before the first clock.
    logic [5:0]  stall_c;
    logic        start_c;
    logic        cancel_c;
    logic        valid_c;
    logic        load_use;

    // A load in EX whose destination is read in ID cannot be forwarded yet:
    // the data only exists at the end of MEM. r0 never creates a hazard.
    always_comb begin
        load_use = ex_is_load_i & ex_wreg_i & (ex_waddr_i != 5'd0) &
                   ((id_rs_ren_i & (id_rs_i == ex_waddr_i)) |
                    (id_rt_ren_i & (id_rt_i == ex_waddr_i)));
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        div_result_d  = div_result_q;
        div_timeout_d = div_timeout_q;
        stall_c       = STALL_NONE;
        start_c       = 1'b0;
        cancel_c      = 1'b0;
        valid_c       = 1'b0;

        if (flush_i) begin
            // Flush beats everything, including a same-cycle div_ready:
            // the result belongs to a cancelled instruction and is dropped.
            state_d  = ST_IDLE;
            cancel_c = (state_q == ST_DIV_RUN);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ex_div_req_i) begin
                        // The EX hold also covers any load-use in ID.
                        start_c = 1'b1;
                        stall_c = STALL_DIV;
                        cyc_d   = 6'd0;
                        state_d = ST_DIV_RUN;
                    end else begin
                        stall_c = load_use ? STALL_LOAD : STALL_NONE;
                    end
                end

                ST_DIV_RUN: begin
                    stall_c = STALL_DIV;
                    if (div_ready_i) begin
                        div_result_d = div_result_i;
                        state_d      = ST_DIV_DONE;
                    end else if (cyc_q == CYC_LAST) begin
                        // Divider never answered: release the pipe with a
                        // zero result and leave a sticky flag behind.
                        div_timeout_d = 1'b1;
                        div_result_d  = 64'd0;
                        state_d       = ST_DIV_DONE;
                    end else begin
                        cyc_d = cyc_q + 6'd1;
                    end
                end

                ST_DIV_DONE: begin
                    // ex_div_req_i is still high for the finishing divide;
                    // going straight to IDLE without looking at it is what
                    // keeps the divider from being restarted.
                    stall_c = load_use ? STALL_LOAD : STALL_NONE;
                    valid_c = 1'b1;
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_o            = rst ? STALL_NONE : stall_c;
        div_start_o        = ~rst & start_c;
        div_cancel_o       = ~rst & cancel_c;
        div_result_valid_o = ~rst & valid_c;
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_comb begin
        load_cnt_d = load_cnt_q;
        div_cnt_d  = div_cnt_q;
        if ((stall_c == STALL_LOAD) && (state_q != ST_DIV_RUN) && (load_cnt_q != CNT_MAX)) begin
            load_cnt_d = load_cnt_q + 32'd1;
        end
        if (stall_c[3] && (div_cnt_q != CNT_MAX)) begin
            div_cnt_d = div_cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cyc_q         <= 6'd0;
            div_result_q  <= 64'd0;
            div_timeout_q <= 1'b0;
            load_cnt_q    <= 32'd0;
            div_cnt_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            div_result_q  <= div_result_d;
            div_timeout_q <= div_timeout_d;
            load_cnt_q    <= load_cnt_d;
            div_cnt_q     <= div_cnt_d;
        end
    end

    assign div_result_q_o   = div_result_q;
    assign div_timeout_o    = div_timeout_q;
    assign load_stall_cnt_o = load_cnt_q;
    assign div_stall_cnt_o  = div_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stall_ctrl
// Description : Directed self-checking bench for stall_ctrl. Inputs change on
//               the falling edge; outputs are sampled 2 ns later, well away
//               from the rising (active) edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_ctrl;

    localparam int DIV_MAX_CYCLES = 40;
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LOAD = 6'b000111;
    localparam logic [5:0] S_DIV  = 6'b001111;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        id_rs_ren_i;
    logic [4:0]  id_rs_i;
    logic        id_rt_ren_i;
    logic [4:0]  id_rt_i;
    logic        ex_is_load_i;
    logic        ex_wreg_i;
    logic [4:0]  ex_waddr_i;
    logic        ex_div_req_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic [5:0]  stall_o;
    logic        div_start_o;
    logic        div_cancel_o;
    logic [63:0] div_result_q_o;
    logic        div_result_valid_o;
    logic        div_timeout_o;
    logic [31:0] load_stall_cnt_o;
    logic [31:0] div_stall_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    stall_ctrl #(.DIV_MAX_CYCLES(DIV_MAX_CYCLES)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .id_rs_ren_i        (id_rs_ren_i),
        .id_rs_i            (id_rs_i),
        .id_rt_ren_i        (id_rt_ren_i),
        .id_rt_i            (id_rt_i),
        .ex_is_load_i       (ex_is_load_i),
        .ex_wreg_i          (ex_wreg_i),
        .ex_waddr_i         (ex_waddr_i),
        .ex_div_req_i       (ex_div_req_i),
        .div_ready_i        (div_ready_i),
        .div_result_i       (div_result_i),
        .stall_o            (stall_o),
        .div_start_o        (div_start_o),
        .div_cancel_o       (div_cancel_o),
        .div_result_q_o     (div_result_q_o),
        .div_result_valid_o (div_result_valid_o),
        .div_timeout_o      (div_timeout_o),
        .load_stall_cnt_o   (load_stall_cnt_o),
        .div_stall_cnt_o    (div_stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 ns");
        $fatal(1, "time limit");
    end

    task automatic clear_inputs();
        flush_i      = 1'b0;
        id_rs_ren_i  = 1'b0;
        id_rs_i      = 5'd0;
        id_rt_ren_i  = 1'b0;
        id_rt_i      = 5'd0;
        ex_is_load_i = 1'b0;
        ex_wreg_i    = 1'b0;
        ex_waddr_i   = 5'd0;
        ex_div_req_i = 1'b0;
        div_ready_i  = 1'b0;
        div_result_i = 64'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        // Load-use inputs applied under reset must not reach stall_o.
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_waddr_i = 5'd5;
        id_rs_ren_i = 1'b1; id_rs_i = 5'd5; ex_div_req_i = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        n_cmp++; if (stall_o !== S_NONE) begin n_fail++; $display("FAIL reset_stall: got %b want %b", stall_o, S_NONE); end
        n_cmp++; if (div_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", div_start_o); end
        n_cmp++; if (div_result_q_o !== 64'd0 || div_timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_div_regs: got res=%h to=%b want 0/0", div_result_q_o, div_timeout_o); end
        n_cmp++; if (load_stall_cnt_o !== 32'd0 || div_stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", load_stall_cnt_o, div_stall_cnt_o); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #2;
        n_cmp++; if (stall_o !== S_NONE || div_result_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got stall=%b valid=%b want 000000/0", stall_o, div_result_valid_o); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_waddr_i = 5'd5;
        id_rs_ren_i = 1'b1; id_rs_i = 5'd5;
        #2;
        n_cmp++; if (stall_o !== S_LOAD) begin n_fail++; $display("FAIL load_use_stall: got %b want %b", stall_o, S_LOAD); end
        // Next cycle the load has moved to MEM and a bubble sits in EX.
        @(negedge clk);
        ex_is_load_i = 1'b0; ex_wreg_i = 1'b0; ex_waddr_i = 5'd0;
        #2;
        n_cmp++; if (stall_o !== S_NONE) begin n_fail++; $display("FAIL load_use_release: got %b want %b", stall_o, S_NONE); end
        n_cmp++; if (load_stall_cnt_o !== 32'd1 || div_stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL load_use_cnt: got %0d/%0d want 1/0", load_stall_cnt_o, div_stall_cnt_o); end
        clear_inputs();
    endtask

    task automatic test_no_stall();
        @(negedge clk);
        ex_is_load_i = 1'b1; ex_wreg_i = 1'b1; ex_waddr_i = 5'd0;
        id_rs_ren_i = 1'b1; id_rs_i = 5'd0;
        #2;
        n_cmp++; if (stall_o !== S_NONE) begin n_fail++; $display("FAIL no_stall_r0: got %b want %b", stall_o, S_NONE); end
        @(negedge clk);
        ex_waddr_i = 5'd5; id_rs_i = 5'd5; id_rs_ren_i = 1'b0;
        #2;
        n_cmp++; if (stall_o !== S_NONE) begin n_fail++; $display("FAIL no_stall_noren: got %b want %b", stall_o, S_NONE); end
        @(negedge clk);
        ex_wreg_i = 1'b0; id_rs_ren_i = 1'b1;
        #2;
        n_cmp++; if (stall_o !== S_NONE) begin n_fail++; $display("FAIL no_stall_nowreg: got %b want %b", stall_o, S_NONE); end
        // rt-side hazard
        @(negedge clk);
        ex_wreg_i = 1'b1; ex_waddr_i = 5'd7; id_rs_i = 5'd3; id_rt_ren_i = 1'b1; id_rt_i = 5'd7;
        #2;
        n_cmp++; if (stall_o !== S_LOAD) begin n_fail++; $display("FAIL load_use_rt: got %b want %b", stall_o, S_LOAD); end
        @(negedge clk);
        clear_inputs();
        #2;
        n_cmp++; if (load_stall_cnt_o !== 32'd2) begin n_fail++; $display("FAIL no_stall_cnt: got %0d want 2", load_stall_cnt_o); end
    endtask

    // div_ready arrives 33 cycles after the request: 34 stall cycles.
    task automatic test_divide();
        int starts;
        int bad_run;
        starts  = 0;
        bad_run = 0;
        @(negedge clk);
        ex_div_req_i = 1'b1;
        #2;
        n_cmp++; if (div_start_o !== 1'b1 || stall_o !== S_DIV) begin n_fail++; $display("FAIL div_req_cycle: got start=%b stall=%b want 1/%b", div_start_o, stall_o, S_DIV); end
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (i == 33) begin div_ready_i = 1'b1; div_result_i = 64'h1_2; end
            #2;
            if (div_start_o) starts++;
            if (stall_o !== S_DIV) bad_run++;
        end
        n_cmp++; if (bad_run != 0 || starts != 0) begin n_fail++; $display("FAIL div_run: got %0d bad stall cycles, %0d extra starts, want 0/0", bad_run, starts); end
        @(negedge clk);
        div_ready_i = 1'b0; div_result_i = 64'd0;
        #2;
        n_cmp++; if (div_result_valid_o !== 1'b1 || stall_o !== S_NONE || div_start_o !== 1'b0) begin n_fail++; $display("FAIL div_done: got valid=%b stall=%b start=%b want 1/000000/0", div_result_valid_o, stall_o, div_start_o); end
        n_cmp++; if (div_result_q_o !== 64'h1_2) begin n_fail++; $display("FAIL div_result: got %h want %h", div_result_q_o, 64'h1_2); end
        @(negedge clk);
        ex_div_req_i = 1'b0;
        #2;
        n_cmp++; if (div_result_valid_o !== 1'b0 || stall_o !== S_NONE) begin n_fail++; $display("FAIL div_after_done: got valid=%b stall=%b want 0/000000", div_result_valid_o, stall_o); end
        n_cmp++; if (div_stall_cnt_o !== 32'd34 || load_stall_cnt_o !== 32'd2) begin n_fail++; $display("FAIL div_cnt: got div=%0d load=%0d want 34/2", div_stall_cnt_o, load_stall_cnt_o); end
    endtask

    // Two divides issued back to back with k=1 then k=2.
    task automatic test_back_to_back();
        @(negedge clk);
        ex_div_req_i = 1'b1; div_result_i = 64'hAAAA;
        #2;
        n_cmp++; if (div_start_o !== 1'b1) begin n_fail++; $display("FAIL b2b_start1: got %b want 1", div_start_o); end
        @(negedge clk);
        div_ready_i = 1'b1;
        #2;
        n_cmp++; if (stall_o !== S_DIV || div_start_o !== 1'b0) begin n_fail++; $display("FAIL b2b_run1: got stall=%b start=%b want %b/0", stall_o, div_start_o, S_DIV); end
        @(negedge clk);
        div_ready_i = 1'b0;
        #2;
        n_cmp++; if (div_result_valid_o !== 1'b1 || div_start_o !== 1'b0 || div_result_q_o !== 64'hAAAA) begin n_fail++; $display("FAIL b2b_done1: got valid=%b start=%b res=%h want 1/0/aaaa", div_result_valid_o, div_start_o, div_result_q_o); end
        @(negedge clk);
        div_result_i = 64'hBBBB;
        #2;
        n_cmp++; if (div_start_o !== 1'b1 || stall_o !== S_DIV) begin n_fail++; $display("FAIL b2b_start2: got start=%b stall=%b want 1/%b", div_start_o, stall_o, S_DIV); end
        @(negedge clk);
        #2;
        n_cmp++; if (stall_o !== S_DIV || div_start_o !== 1'b0) begin n_fail++; $display("FAIL b2b_run2: got stall=%b start=%b want %b/0", stall_o, div_start_o, S_DIV); end
        @(negedge clk);
        div_ready_i = 1'b1;
        #2;
        @(negedge clk);
        div_ready_i = 1'b0;
        #2;
        n_cmp++; if (div_result_valid_o !== 1'b1 || div_result_q_o !== 64'hBBBB) begin n_fail++; $display("FAIL b2b_done2: got valid=%b res=%h want 1/bbbb", div_result_valid_o, div_result_q_o); end
        @(negedge clk);
        clear_inputs();
        #2;
        n_cmp++; if (div_stall_cnt_o !== 32'd39) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 39", div_stall_cnt_o); end
    endtask

    // No div_ready: request cycle + 40 RUN cycles stalled, then DONE.
    task automatic test_watchdog();
        int bad_run;
        bad_run = 0;
        @(negedge clk);
        ex_div_req_i = 1'b1;
        #2;
        n_cmp++; if (div_start_o !== 1'b1) begin n_fail++; $display("FAIL wd_start: got %b want 1", div_start_o); end
        for (int i = 1; i <= DIV_MAX_CYCLES; i++) begin
            @(negedge clk);
            #2;
            if (stall_o !== S_DIV || div_result_valid_o !== 1'b0) bad_run++;
        end
        n_cmp++; if (bad_run != 0) begin n_fail++; $display("FAIL wd_run: got %0d bad cycles want 0", bad_run); end
        @(negedge clk);
        #2;
        n_cmp++; if (div_result_valid_o !== 1'b1 || stall_o !== S_NONE) begin n_fail++; $display("FAIL wd_done: got valid=%b stall=%b want 1/000000", div_result_valid_o, stall_o); end
        n_cmp++; if (div_timeout_o !== 1'b1 || div_result_q_o !== 64'd0) begin n_fail++; $display("FAIL wd_flag: got to=%b res=%h want 1/0", div_timeout_o, div_result_q_o); end
        @(negedge clk);
        ex_div_req_i = 1'b0;
        #2;
        @(negedge clk);
        #2;
        n_cmp++; if (div_timeout_o !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %b want 1", div_timeout_o); end
        n_cmp++; if (div_stall_cnt_o !== 32'd80) begin n_fail++; $display("FAIL wd_cnt: got %0d want 80", div_stall_cnt_o); end
    endtask

    // Flush with a simultaneous div_ready in RUN cycle 10.
    task automatic test_flush();
        @(negedge clk);
        ex_div_req_i = 1'b1;
        #2;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            #2;
        end
        n_cmp++; if (div_cancel_o !== 1'b0 || stall_o !== S_DIV) begin n_fail++; $display("FAIL flush_pre: got cancel=%b stall=%b want 0/%b", div_cancel_o, stall_o, S_DIV); end
        @(negedge clk);
        flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = 64'hDEAD;
        #2;
        n_cmp++; if (div_cancel_o !== 1'b1 || stall_o !== S_NONE || div_start_o !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: got cancel=%b stall=%b start=%b want 1/000000/0", div_cancel_o, stall_o, div_start_o); end
        @(negedge clk);
        clear_inputs();
        #2;
        n_cmp++; if (div_result_q_o !== 64'd0 || div_result_valid_o !== 1'b0 || div_cancel_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got res=%h valid=%b cancel=%b want 0/0/0", div_result_q_o, div_result_valid_o, div_cancel_o); end
        n_cmp++; if (div_stall_cnt_o !== 32'd90 || div_timeout_o !== 1'b1) begin n_fail++; $display("FAIL flush_cnt: got cnt=%0d to=%b want 90/1", div_stall_cnt_o, div_timeout_o); end
        @(negedge clk);
        div_ready_i = 1'b1; div_result_i = 64'hBEEF;
        #2;
        n_cmp++; if (stall_o !== S_NONE || div_result_valid_o !== 1'b0) begin n_fail++; $display("FAIL stray_ready: got stall=%b valid=%b want 000000/0", stall_o, div_result_valid_o); end
        @(negedge clk);
        clear_inputs();
        #2;
        n_cmp++; if (div_result_q_o !== 64'd0) begin n_fail++; $display("FAIL stray_ready_latch: got %h want 0", div_result_q_o); end
    endtask

    // Asynchronous reset in the middle of a divide, away from any clock edge.
    task automatic test_async_reset();
        @(negedge clk);
        ex_div_req_i = 1'b1;
        #2;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (stall_o !== S_NONE || div_start_o !== 1'b0 || div_cancel_o !== 1'b0) begin n_fail++; $display("FAIL arst_comb: got stall=%b start=%b cancel=%b want 000000/0/0", stall_o, div_start_o, div_cancel_o); end
        n_cmp++; if (load_stall_cnt_o !== 32'd0 || div_stall_cnt_o !== 32'd0 || div_timeout_o !== 1'b0) begin n_fail++; $display("FAIL arst_regs: got load=%0d div=%0d to=%b want 0/0/0", load_stall_cnt_o, div_stall_cnt_o, div_timeout_o); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ex_div_req_i = 1'b0;
        @(negedge clk);
        ex_div_req_i = 1'b1;
        #2;
        n_cmp++; if (div_start_o !== 1'b1 || stall_o !== S_DIV) begin n_fail++; $display("FAIL arst_restart: got start=%b stall=%b want 1/%b", div_start_o, stall_o, S_DIV); end
        @(negedge clk);
        div_ready_i = 1'b1; div_result_i = 64'h5;
        #2;
        @(negedge clk);
        div_ready_i = 1'b0;
        #2;
        n_cmp++; if (div_result_valid_o !== 1'b1 || div_result_q_o !== 64'h5) begin n_fail++; $display("FAIL arst_done: got valid=%b res=%h want 1/5", div_result_valid_o, div_result_q_o); end
        @(negedge clk);
        clear_inputs();
        #2;
        n_cmp++; if (div_stall_cnt_o !== 32'd2 || load_stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL arst_cnt: got div=%0d load=%0d want 2/0", div_stall_cnt_o, load_stall_cnt_o); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_no_stall();
        test_divide();
        test_back_to_back();
        test_watchdog();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
